// File: rtl/iopipe_tx_chan_mux.sv
// -----------------------------------------------------------------------------
// iopipe_tx_chan_mux
//
// Egress multiplexer for the I/O-pipe path. Up to NUM_CHAN kernel write pipes
// present AVST beats; one channel at a time is granted round-robin and its
// beats are framed into a packet (sop/eop, channel ID) on a single AVST stream.
// A packet closes either when PKT_WORDS beats have been taken or when the
// granted source has been silent for IDLE_TIMEOUT cycles with a beat pending.
//
// Ports
//   clk         sole clock
//   reset_n     synchronous, active-low reset
//   in_valid    per-channel source valid            [NUM_CHAN]
//   in_data     per-channel data, chan i at [i*DATA_W +: DATA_W]
//   in_ready    per-channel ready, readyLatency 0   [NUM_CHAN]
//   tx_valid    egress valid
//   tx_data     egress data                         [DATA_W]
//   tx_sop      first beat of packet
//   tx_eop      last beat of packet
//   tx_chan     source channel of current packet    [CHAN_W]
//   tx_ready    egress ready, readyLatency 0
//   tx_pkt_cnt  packets emitted, wraps mod 2^32
// -----------------------------------------------------------------------------
module iopipe_tx_chan_mux #(
  parameter int NUM_CHAN     = 16,
  parameter int DATA_W       = 64,
  parameter int PKT_WORDS    = 8,
  parameter int IDLE_TIMEOUT = 32,
  parameter int CHAN_W       = $clog2(NUM_CHAN)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CHAN-1:0]        in_valid,
  input  logic [NUM_CHAN*DATA_W-1:0] in_data,
  output logic [NUM_CHAN-1:0]        in_ready,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_sop,
  output logic                       tx_eop,
  output logic [CHAN_W-1:0]          tx_chan,
  input  logic                       tx_ready,
  output logic [31:0]                tx_pkt_cnt
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [7:0]      PKT_WORDS_C = 8'(PKT_WORDS);
  localparam logic [15:0]     TIMEOUT_C   = 16'(IDLE_TIMEOUT);
  localparam logic [CHAN_W:0] NUM_CHAN_C  = (CHAN_W+1)'(NUM_CHAN);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);

  state_t              state_q, state_d;
  logic [CHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_v_q, hold_v_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic                closing_q, closing_d;
  logic                sop_pend_q, sop_pend_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;

  // Per-channel data unpacked so the granted channel can be selected by index.
  logic [DATA_W-1:0]   in_data_arr [NUM_CHAN];
  // Channel index visited at each search offset from rr_ptr, already wrapped.
  logic [CHAN_W:0]     wrap_idx [NUM_CHAN];

  logic                grant_found;
  logic [CHAN_W-1:0]   grant_idx;
  logic                in_valid_g;
  logic [DATA_W-1:0]   in_data_g;
  logic                rdy_g;
  logic                load;
  logic                len_done;
  logic                tx_accept;
  logic                eop_accept;

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
    logic [CHAN_W:0] sum;
    assign in_data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
    assign sum             = {1'b0, rr_ptr_q} + (CHAN_W+1)'(gi);
    assign wrap_idx[gi]    = (sum >= NUM_CHAN_C) ? (sum - NUM_CHAN_C) : sum;
    assign in_ready[gi]    = rdy_g && (chan_q == CHAN_W'(gi));
  end

  // Round-robin search: walk offsets from the far end down so the smallest
  // offset from rr_ptr with a valid source wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CHAN - 1; k >= 0; k--) begin
      if (in_valid[wrap_idx[k][CHAN_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx[k][CHAN_W-1:0];
      end
    end
  end

  assign in_valid_g = in_valid[chan_q];
  assign in_data_g  = in_data_arr[chan_q];
  assign len_done   = (beat_cnt_q == PKT_WORDS_C);

  assign rdy_g      = (state_q == S_STREAM) && !closing_q &&
                      (beat_cnt_q < PKT_WORDS_C) && (!hold_v_q || tx_ready);
  assign load       = in_valid_g && rdy_g;

  // A held beat is only offered when its eop status is known: either the
  // packet is closing, or another beat is already waiting behind it.
  assign tx_valid   = hold_v_q && (len_done || closing_q || in_valid_g);
  assign tx_eop     = hold_v_q && (len_done || closing_q);
  assign tx_sop     = sop_pend_q && tx_valid;
  assign tx_data    = hold_q;
  assign tx_chan    = chan_q;
  assign tx_pkt_cnt = pkt_cnt_q;

  assign tx_accept  = tx_valid && tx_ready;
  assign eop_accept = tx_accept && tx_eop;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    chan_d     = chan_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    closing_d  = closing_q;
    sop_pend_d = sop_pend_q;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          chan_d     = grant_idx;
          rr_ptr_d   = (grant_idx == LAST_CHAN) ? '0 : grant_idx + 1'b1;
          sop_pend_d = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (load) begin
          hold_d     = in_data_g;
          hold_v_d   = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          idle_cnt_d = '0;
        end else if (hold_v_q && !in_valid_g && !closing_q) begin
          // Closing is raised one cycle after the count reaches the limit,
          // so a beat arriving in that cycle still extends the packet.
          if (idle_cnt_q == TIMEOUT_C) closing_d = 1'b1;
          else                         idle_cnt_d = idle_cnt_q + 16'd1;
        end
        if (tx_accept) sop_pend_d = 1'b0;
        if (eop_accept) begin
          hold_v_d   = 1'b0;
          beat_cnt_d = '0;
          closing_d  = 1'b0;
          idle_cnt_d = '0;
          pkt_cnt_d  = pkt_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      chan_q     <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      closing_q  <= 1'b0;
      sop_pend_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      chan_q     <= chan_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      closing_q  <= closing_d;
      sop_pend_q <= sop_pend_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_iopipe_tx_chan_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_iopipe_tx_chan_mux
//
// Directed bench for iopipe_tx_chan_mux with default parameters
// (16 channels, 64-bit beats, 8-beat packets, 32-cycle idle timeout).
// Each source channel c emits beats {c, 24'h0, seq}; seq advances on every
// accepted input beat, so ordering, loss and duplication are all visible in
// the egress data.
// -----------------------------------------------------------------------------
module tb_iopipe_tx_chan_mux;
  localparam int NCH = 16;
  localparam int DW  = 64;
  localparam int PKT = 8;
  localparam int TMO = 32;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              tx_valid, tx_sop, tx_eop;
  logic              tx_ready = 1'b1;
  logic [DW-1:0]     tx_data;
  logic [CW-1:0]     tx_chan;
  logic [31:0]       tx_pkt_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  int seq [NCH];
  int lim [NCH];
  bit en  [NCH];
  int last_load [NCH];

  // accepted egress beats
  logic [DW-1:0] q_data [$];
  bit            q_sop  [$];
  bit            q_eop  [$];
  logic [CW-1:0] q_chan [$];
  int            q_cyc  [$];

  // outputs captured in the most recent sampled cycle
  logic          s_tx_valid, s_tx_ready, s_tx_sop, s_tx_eop;
  logic [CW-1:0] s_tx_chan;
  logic [DW-1:0] s_tx_data;
  logic [NCH-1:0] s_in_ready;
  logic [31:0]   s_pkt_cnt;

  always #5 clk = ~clk;

  iopipe_tx_chan_mux dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .tx_chan    (tx_chan),
    .tx_ready   (tx_ready),
    .tx_pkt_cnt (tx_pkt_cnt)
  );

  function automatic logic [DW-1:0] mk(int c, int s);
    mk = {8'(c), 24'd0, 32'(s)};
  endfunction

  always_comb begin
    in_data = '0;
    for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = mk(c, seq[c]);
  end

  task automatic apply_valid();
    for (int c = 0; c < NCH; c++) in_valid[c] = en[c] && (seq[c] < lim[c]);
  endtask

  // One clock: sample at negedge, then advance sources just after posedge.
  task automatic tick();
    logic [NCH-1:0] acc;
    @(negedge clk);
    s_tx_valid = tx_valid;
    s_tx_ready = tx_ready;
    s_tx_sop   = tx_sop;
    s_tx_eop   = tx_eop;
    s_tx_chan  = tx_chan;
    s_tx_data  = tx_data;
    s_in_ready = in_ready;
    s_pkt_cnt  = tx_pkt_cnt;
    acc = in_valid & in_ready;
    if (reset_n && tx_valid && tx_ready) begin
      q_data.push_back(tx_data);
      q_sop.push_back(tx_sop);
      q_eop.push_back(tx_eop);
      q_chan.push_back(tx_chan);
      q_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c] && reset_n) begin
        seq[c]++;
        last_load[c] = cyc - 1;
      end
    end
    apply_valid();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_sop.delete();
    q_eop.delete();
    q_chan.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      en[c] = 1'b0; lim[c] = 0; seq[c] = 0; last_load[c] = 0;
    end
    apply_valid();
    tick();
    tick();
    reset_n = 1'b1;
    clear_q();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    vec_cnt++; if (s_tx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_valid: got %0b expected 0", s_tx_valid); end
    vec_cnt++; if (s_tx_sop !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_sop: got %0b expected 0", s_tx_sop); end
    vec_cnt++; if (s_tx_eop !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_eop: got %0b expected 0", s_tx_eop); end
    vec_cnt++; if (s_tx_chan !== 4'd0) begin err_cnt++; $display("FAIL reset_tx_chan: got %0h expected 0", s_tx_chan); end
    vec_cnt++; if (s_tx_data !== 64'd0) begin err_cnt++; $display("FAIL reset_tx_data: got %0h expected 0", s_tx_data); end
    vec_cnt++; if (s_in_ready !== 16'd0) begin err_cnt++; $display("FAIL reset_in_ready: got %0h expected 0", s_in_ready); end
    vec_cnt++; if (s_pkt_cnt !== 32'd0) begin err_cnt++; $display("FAIL reset_pkt_cnt: got %0d expected 0", s_pkt_cnt); end
    $display("test_reset: outputs sampled after reset");
  endtask

  task automatic test_single_packet();
    do_reset();
    en[3] = 1'b1; lim[3] = 8;
    apply_valid();
    repeat (14) tick();
    vec_cnt++;
    if (q_data.size() != 8) begin
      err_cnt++; $display("FAIL single_beats: got %0d expected 8", q_data.size());
    end else begin
      // grant in cycle 0, load in cycle 1, first beat offered in cycle 2
      vec_cnt++; if (q_cyc[0] != 2) begin err_cnt++; $display("FAIL single_first_cycle: got %0d expected 2", q_cyc[0]); end
      for (int i = 0; i < 8; i++) begin
        vec_cnt++; if (q_data[i] !== mk(3, i)) begin err_cnt++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, q_data[i], mk(3, i)); end
        vec_cnt++; if (q_sop[i] !== (i == 0)) begin err_cnt++; $display("FAIL single_sop[%0d]: got %0b expected %0b", i, q_sop[i], (i == 0)); end
        vec_cnt++; if (q_eop[i] !== (i == 7)) begin err_cnt++; $display("FAIL single_eop[%0d]: got %0b expected %0b", i, q_eop[i], (i == 7)); end
        vec_cnt++; if (q_chan[i] !== 4'd3) begin err_cnt++; $display("FAIL single_chan[%0d]: got %0d expected 3", i, q_chan[i]); end
        vec_cnt++; if (q_cyc[i] != 2 + i) begin err_cnt++; $display("FAIL single_cycle[%0d]: got %0d expected %0d", i, q_cyc[i], 2 + i); end
      end
    end
    vec_cnt++; if (s_pkt_cnt !== 32'd1) begin err_cnt++; $display("FAIL single_pkt_cnt: got %0d expected 1", s_pkt_cnt); end
    $display("test_single_packet: %0d beats on channel 3", q_data.size());
  endtask

  task automatic test_timeout();
    do_reset();
    en[5] = 1'b1; lim[5] = 3;
    apply_valid();
    repeat (45) tick();
    vec_cnt++;
    if (q_data.size() != 3) begin
      err_cnt++; $display("FAIL timeout_beats: got %0d expected 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vec_cnt++; if (q_data[i] !== mk(5, i)) begin err_cnt++; $display("FAIL timeout_data[%0d]: got %0h expected %0h", i, q_data[i], mk(5, i)); end
        vec_cnt++; if (q_eop[i] !== (i == 2)) begin err_cnt++; $display("FAIL timeout_eop[%0d]: got %0b expected %0b", i, q_eop[i], (i == 2)); end
      end
      vec_cnt++; if (q_sop[0] !== 1'b1) begin err_cnt++; $display("FAIL timeout_sop: got %0b expected 1", q_sop[0]); end
      // last load takes effect at the edge ending cycle 3; eop is offered
      // TMO+1 cycles after that edge, i.e. in cycle 3 + 1 + 33 = 37
      vec_cnt++; if (last_load[5] != 3) begin err_cnt++; $display("FAIL timeout_last_load: got %0d expected 3", last_load[5]); end
      vec_cnt++; if (q_cyc[2] != 37) begin err_cnt++; $display("FAIL timeout_eop_cycle: got %0d expected 37", q_cyc[2]); end
    end
    vec_cnt++; if (s_pkt_cnt !== 32'd1) begin err_cnt++; $display("FAIL timeout_pkt_cnt: got %0d expected 1", s_pkt_cnt); end
    $display("test_timeout: %0d beats on channel 5", q_data.size());
  endtask

  task automatic test_round_robin();
    int order [3];
    int ch;
    order[0] = 0; order[1] = 2; order[2] = 15;
    do_reset();
    en[0] = 1'b1; en[2] = 1'b1; en[15] = 1'b1;
    lim[0] = 1000; lim[2] = 1000; lim[15] = 1000;
    apply_valid();
    // each packet: grant cycle + 8 loads + eop cycle = 10 cycles
    repeat (62) tick();
    vec_cnt++;
    if (q_data.size() != 48) begin
      err_cnt++; $display("FAIL rr_beats: got %0d expected 48", q_data.size());
    end else begin
      for (int p = 0; p < 6; p++) begin
        ch = order[p % 3];
        for (int i = 0; i < 8; i++) begin
          vec_cnt++; if (q_chan[p*8+i] !== 4'(ch)) begin err_cnt++; $display("FAIL rr_chan[%0d]: got %0d expected %0d", p*8+i, q_chan[p*8+i], ch); end
          vec_cnt++; if (q_data[p*8+i] !== mk(ch, (p/3)*8 + i)) begin err_cnt++; $display("FAIL rr_data[%0d]: got %0h expected %0h", p*8+i, q_data[p*8+i], mk(ch, (p/3)*8 + i)); end
          vec_cnt++; if (q_sop[p*8+i] !== (i == 0)) begin err_cnt++; $display("FAIL rr_sop[%0d]: got %0b expected %0b", p*8+i, q_sop[p*8+i], (i == 0)); end
          vec_cnt++; if (q_eop[p*8+i] !== (i == 7)) begin err_cnt++; $display("FAIL rr_eop[%0d]: got %0b expected %0b", p*8+i, q_eop[p*8+i], (i == 7)); end
        end
      end
    end
    vec_cnt++; if (s_pkt_cnt !== 32'd6) begin err_cnt++; $display("FAIL rr_pkt_cnt: got %0d expected 6", s_pkt_cnt); end
    $display("test_round_robin: %0d beats over channels 0,2,15", q_data.size());
  endtask

  task automatic test_backpressure();
    do_reset();
    en[1] = 1'b1; lim[1] = 16;
    apply_valid();
    for (int n = 0; n < 60; n++) begin
      tick();
      if (s_tx_valid && !s_tx_ready) begin
        vec_cnt++;
        if (s_in_ready[1] !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready cycle %0d: got 1 expected 0", cyc - 1); end
      end
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    vec_cnt++;
    if (q_data.size() != 16) begin
      err_cnt++; $display("FAIL bp_beats: got %0d expected 16", q_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vec_cnt++; if (q_data[i] !== mk(1, i)) begin err_cnt++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, q_data[i], mk(1, i)); end
        vec_cnt++; if (q_sop[i] !== (i % 8 == 0)) begin err_cnt++; $display("FAIL bp_sop[%0d]: got %0b expected %0b", i, q_sop[i], (i % 8 == 0)); end
        vec_cnt++; if (q_eop[i] !== (i % 8 == 7)) begin err_cnt++; $display("FAIL bp_eop[%0d]: got %0b expected %0b", i, q_eop[i], (i % 8 == 7)); end
        vec_cnt++; if (q_chan[i] !== 4'd1) begin err_cnt++; $display("FAIL bp_chan[%0d]: got %0d expected 1", i, q_chan[i]); end
      end
    end
    vec_cnt++; if (s_pkt_cnt !== 32'd2) begin err_cnt++; $display("FAIL bp_pkt_cnt: got %0d expected 2", s_pkt_cnt); end
    $display("test_backpressure: %0d beats on channel 1", q_data.size());
  endtask

  task automatic test_timeout_race();
    int w;
    int guard;
    do_reset();
    en[4] = 1'b1; lim[4] = 1;
    apply_valid();
    guard = 0;
    while (seq[4] == 0 && guard < 20) begin tick(); guard++; end
    vec_cnt++;
    if (seq[4] == 0) begin
      err_cnt++; $display("FAIL race_first_load: got 0 loads expected 1");
    end else begin
      w = last_load[4];
      // idle count equals the timeout in cycle w+33; the next beat arrives then
      while (cyc < w + 32) tick();
      lim[4] = 2;
      repeat (40) tick();
      vec_cnt++;
      if (q_data.size() != 2) begin
        err_cnt++; $display("FAIL race_beats: got %0d expected 2", q_data.size());
      end else begin
        vec_cnt++; if (q_eop[0] !== 1'b0) begin err_cnt++; $display("FAIL race_early_eop: got 1 expected 0"); end
        vec_cnt++; if (q_sop[0] !== 1'b1) begin err_cnt++; $display("FAIL race_sop: got %0b expected 1", q_sop[0]); end
        vec_cnt++; if (q_cyc[0] != w + 33) begin err_cnt++; $display("FAIL race_beat0_cycle: got %0d expected %0d", q_cyc[0], w + 33); end
        vec_cnt++; if (q_data[1] !== mk(4, 1)) begin err_cnt++; $display("FAIL race_data1: got %0h expected %0h", q_data[1], mk(4, 1)); end
        vec_cnt++; if (q_eop[1] !== 1'b1) begin err_cnt++; $display("FAIL race_eop1: got %0b expected 1", q_eop[1]); end
        vec_cnt++; if (q_cyc[1] != w + 67) begin err_cnt++; $display("FAIL race_eop_cycle: got %0d expected %0d", q_cyc[1], w + 67); end
      end
      vec_cnt++; if (s_pkt_cnt !== 32'd1) begin err_cnt++; $display("FAIL race_pkt_cnt: got %0d expected 1", s_pkt_cnt); end
    end
    $display("test_timeout_race: %0d beats on channel 4", q_data.size());
  endtask

  task automatic test_reset_mid();
    int guard;
    int eops;
    do_reset();
    en[7] = 1'b1; lim[7] = 1000;
    apply_valid();
    guard = 0;
    while (seq[7] < 4 && guard < 20) begin tick(); guard++; end
    eops = 0;
    foreach (q_eop[i]) if (q_eop[i]) eops++;
    vec_cnt++; if (q_data.size() != 3) begin err_cnt++; $display("FAIL mid_beats_before: got %0d expected 3", q_data.size()); end
    vec_cnt++; if (eops != 0) begin err_cnt++; $display("FAIL mid_eop_before: got %0d expected 0", eops); end
    reset_n = 1'b0;
    en[7] = 1'b0;
    apply_valid();
    tick();
    reset_n = 1'b1;
    clear_q();
    en[3] = 1'b1; lim[3] = 8;
    en[9] = 1'b1; lim[9] = 8;
    apply_valid();
    tick();
    vec_cnt++; if (s_tx_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_tx_valid: got %0b expected 0", s_tx_valid); end
    vec_cnt++; if (s_tx_sop !== 1'b0) begin err_cnt++; $display("FAIL mid_tx_sop: got %0b expected 0", s_tx_sop); end
    vec_cnt++; if (s_tx_eop !== 1'b0) begin err_cnt++; $display("FAIL mid_tx_eop: got %0b expected 0", s_tx_eop); end
    vec_cnt++; if (s_tx_chan !== 4'd0) begin err_cnt++; $display("FAIL mid_tx_chan: got %0d expected 0", s_tx_chan); end
    vec_cnt++; if (s_tx_data !== 64'd0) begin err_cnt++; $display("FAIL mid_tx_data: got %0h expected 0", s_tx_data); end
    vec_cnt++; if (s_in_ready !== 16'd0) begin err_cnt++; $display("FAIL mid_in_ready: got %0h expected 0", s_in_ready); end
    vec_cnt++; if (s_pkt_cnt !== 32'd0) begin err_cnt++; $display("FAIL mid_pkt_cnt: got %0d expected 0", s_pkt_cnt); end
    repeat (12) tick();
    vec_cnt++;
    if (q_data.size() == 0) begin
      err_cnt++; $display("FAIL mid_regrant: got 0 beats expected at least 1");
    end else begin
      // search restarts at channel 0, so channel 3 beats channel 9
      vec_cnt++; if (q_chan[0] !== 4'd3) begin err_cnt++; $display("FAIL mid_regrant_chan: got %0d expected 3", q_chan[0]); end
      vec_cnt++; if (q_data[0] !== mk(3, 0)) begin err_cnt++; $display("FAIL mid_regrant_data: got %0h expected %0h", q_data[0], mk(3, 0)); end
      vec_cnt++; if (q_sop[0] !== 1'b1) begin err_cnt++; $display("FAIL mid_regrant_sop: got %0b expected 1", q_sop[0]); end
    end
    $display("test_reset_mid: %0d beats after reset", q_data.size());
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      seq[c] = 0; lim[c] = 0; en[c] = 1'b0; last_load[c] = 0;
    end
    test_reset();
    test_single_packet();
    test_timeout();
    test_round_robin();
    test_backpressure();
    test_timeout_race();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
